// File: rtl/seg7_bcd_capture.sv
// Reconstructs per-digit BCD from a multiplexed active-low 7-segment bus, with stability filter and error flags.
// Optional macro SEG7_CAPTURE_DP_EN adds decimal-point capture (dp input, dp_out output).
module seg7_bcd_capture #(
    parameter int NUM_DIGITS = 6,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    err_clr,
`ifdef SEG7_CAPTURE_DP_EN
    input  logic                    dp,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   err_invalid,
    output logic                    err_mux,
    output logic                    frame_done
);

`ifdef SEG7_CAPTURE_DP_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    // Returns {valid, code}; blank decodes to a valid 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 5'h10;
            7'b1111001: decode = 5'h11;
            7'b0100100: decode = 5'h12;
            7'b0110000: decode = 5'h13;
            7'b0011001: decode = 5'h14;
            7'b0010010: decode = 5'h15;
            7'b0000010: decode = 5'h16;
            7'b1111000: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0010000: decode = 5'h19;
            7'b1111111: decode = 5'h1F;
            default:    decode = 5'h0F;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v < STABLE) ? v + 4'd1 : v;
    endfunction

    logic [4:0]                     dec;
    logic                           dec_ok;
    logic [3:0]                     code;
    logic [CW-1:0]                  key;
    logic [3:0]                     zero_cnt;
    logic                           sel_ok;
    logic [NUM_DIGITS-1:0]          addr;
    logic [NUM_DIGITS-1:0]          commit;
    logic [NUM_DIGITS-1:0]          seen;
    logic [NUM_DIGITS-1:0]          seen_nxt;
    logic                           frame_hit;
    logic [NUM_DIGITS-1:0][3:0]     cnt;
    logic [NUM_DIGITS-1:0][3:0]     cnt_nxt;
    logic [NUM_DIGITS-1:0][CW-1:0]  cand;

    assign dec    = decode(seg);
    assign dec_ok = dec[4];
    assign code   = dec[3:0];
`ifdef SEG7_CAPTURE_DP_EN
    assign key    = {dp, code};
`else
    assign key    = code;
`endif

    always_comb begin
        zero_cnt = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            zero_cnt = zero_cnt + {3'b000, ~dig_sel[i]};
    end

    assign sel_ok = (zero_cnt == 4'd1);

    always_comb begin
        addr    = '0;
        commit  = '0;
        cnt_nxt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            addr[i]    = sample_en && sel_ok && !dig_sel[i];
            cnt_nxt[i] = (cand[i] == key) ? sat_inc(cnt[i]) : 4'd1;
            commit[i]  = addr[i] && dec_ok && (cnt_nxt[i] == STABLE);
        end
    end

    // A frame completes when the current commit fills the last missing seen bit.
    assign seen_nxt  = seen | commit;
    assign frame_hit = &seen_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out     <= '1;
            digit_valid <= '0;
            err_invalid <= '0;
            err_mux     <= 1'b0;
            frame_done  <= 1'b0;
            seen        <= '0;
            cnt         <= '0;
            cand        <= '0;
`ifdef SEG7_CAPTURE_DP_EN
            dp_out      <= '0;
`endif
        end else begin
            frame_done <= frame_hit;
            seen       <= frame_hit ? '0 : seen_nxt;
            err_mux    <= (err_mux & ~err_clr) | (sample_en & ~sel_ok);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                err_invalid[i] <= (err_invalid[i] & ~err_clr) | (addr[i] & ~dec_ok);
                if (addr[i]) begin
                    if (!dec_ok) begin
                        cnt[i] <= 4'd0;
                    end else begin
                        cand[i] <= key;
                        cnt[i]  <= cnt_nxt[i];
                    end
                end
                if (commit[i]) begin
                    bcd_out[4*i +: 4] <= code;
                    digit_valid[i]    <= 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
                    dp_out[i]         <= ~dp;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Testbench for seg7_bcd_capture: directed scenarios plus randomized scan against a history-based model.
`timescale 1ns/1ps
module tb_seg7_bcd_capture;
    localparam int ND = 6;
    localparam int SC = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sample_en;
    logic            err_clr;
    logic [6:0]      seg;
    logic [ND-1:0]   dig_sel;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0]   digit_valid;
    logic [ND-1:0]   err_invalid;
    logic            err_mux;
    logic            frame_done;
`ifdef SEG7_CAPTURE_DP_EN
    logic            dp = 1'b1;
    logic [ND-1:0]   dp_out;
`endif

    int passed = 0;
    int total  = 0;

    seg7_bcd_capture #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .seg(seg),
        .dig_sel(dig_sel), .err_clr(err_clr),
`ifdef SEG7_CAPTURE_DP_EN
        .dp(dp), .dp_out(dp_out),
`endif
        .bcd_out(bcd_out), .digit_valid(digit_valid), .err_invalid(err_invalid),
        .err_mux(err_mux), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] BAD = 7'b0101010;

    // Model: per-digit history of consecutive valid codes since the last invalid sample or reset.
    int              hist [ND][$];
    logic [4*ND-1:0] m_bcd;
    logic [ND-1:0]   m_valid, m_inv, m_seen;
    logic            m_mux, m_frame;

    function automatic int ref_decode(input logic [6:0] s);
        if (s == 7'b1111111) return 15;
        for (int k = 0; k < 10; k++)
            if (seg_tab[k] == s) return k;
        return -1;
    endfunction

    function automatic logic [ND-1:0] sel_of(input int d);
        return ~(ND'(1) << d);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ND; k++) hist[k].delete();
        m_bcd = '1; m_valid = '0; m_inv = '0; m_seen = '0; m_mux = 1'b0; m_frame = 1'b0;
    endtask

    task automatic apply_reset();
        sample_en = 1'b0; err_clr = 1'b0; seg = 7'h7F; dig_sel = '1;
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic step(input logic en, input logic [ND-1:0] sel, input logic [6:0] s, input logic clr);
        int zeros = 0;
        int d = 0;
        int c = 0;
        bit same;
        logic [ND-1:0] inv_ev = '0;
        logic [ND-1:0] com = '0;
        logic mux_ev = 1'b0;
        sample_en = en; dig_sel = sel; seg = s; err_clr = clr;
        @(posedge clk); #1;
        sample_en = 1'b0; err_clr = 1'b0;
        if (en) begin
            for (int k = 0; k < ND; k++)
                if (!sel[k]) begin zeros++; d = k; end
            if (zeros != 1) mux_ev = 1'b1;
            else begin
                c = ref_decode(s);
                if (c < 0) begin
                    inv_ev[d] = 1'b1;
                    hist[d].delete();
                end else begin
                    hist[d].push_back(c);
                    if (hist[d].size() > SC) void'(hist[d].pop_front());
                    if (hist[d].size() == SC) begin
                        same = 1;
                        for (int k = 0; k < SC; k++)
                            if (hist[d][k] != c) same = 0;
                        if (same) com[d] = 1'b1;
                    end
                end
            end
        end
        for (int k = 0; k < ND; k++)
            if (com[k]) begin m_bcd[4*k +: 4] = 4'(c); m_valid[k] = 1'b1; end
        m_inv  = (clr ? '0 : m_inv) | inv_ev;
        m_mux  = (clr ? 1'b0 : m_mux) | mux_ev;
        m_seen = m_seen | com;
        m_frame = &m_seen;
        if (m_frame) m_seen = '0;
    endtask

    task automatic test_reset();
        bit saw_frame = 0;
        apply_reset();
        total++; if (bcd_out !== 24'hFFFFFF) $display("FAIL reset_bcd: got %h expected ffffff", bcd_out); else passed++;
        total++; if (digit_valid !== '0) $display("FAIL reset_valid: got %b expected 0", digit_valid); else passed++;
        total++; if ({err_invalid, err_mux} !== '0) $display("FAIL reset_err: got %b/%b expected 0", err_invalid, err_mux); else passed++;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '1, 7'h7F, 1'b0);
            if (frame_done !== 1'b0) saw_frame = 1;
        end
        total++; if (saw_frame) $display("FAIL reset_frame: frame_done seen 1 expected 0"); else passed++;
    endtask

    task automatic test_stability();
        for (int n = 1; n <= 3; n++) begin
            step(1'b1, sel_of(2), 7'b0010010, 1'b0);
            total++;
            if (bcd_out[11:8] !== (n == 3 ? 4'h5 : 4'hF) || digit_valid[2] !== (n == 3))
                $display("FAIL stab_s%0d: got %h/%b expected %h/%0d", n, bcd_out[11:8], digit_valid[2], (n == 3 ? 4'h5 : 4'hF), n == 3);
            else passed++;
        end
    endtask

    task automatic test_no_false_commit();
        logic [6:0] seq [5] = '{7'b0000000, 7'b0000000, 7'b1111001, 7'b1111001, 7'b1111001};
        for (int n = 0; n < 5; n++) begin
            step(1'b1, sel_of(0), seq[n], 1'b0);
            total++;
            if (bcd_out[3:0] !== (n == 4 ? 4'h1 : 4'hF))
                $display("FAIL nofalse_s%0d: got %h expected %h", n + 1, bcd_out[3:0], (n == 4 ? 4'h1 : 4'hF));
            else passed++;
        end
    endtask

    task automatic test_invalid();
        for (int n = 0; n < 3; n++) step(1'b1, sel_of(4), 7'b1111000, 1'b0);
        step(1'b1, sel_of(4), BAD, 1'b0);
        total++; if (err_invalid !== 6'b010000) $display("FAIL inv_set: got %b expected 010000", err_invalid); else passed++;
        total++; if (bcd_out[19:16] !== 4'h7) $display("FAIL inv_keep: got %h expected 7", bcd_out[19:16]); else passed++;
        total++; if (err_mux !== 1'b0) $display("FAIL inv_mux: got %b expected 0", err_mux); else passed++;
        step(1'b0, '1, 7'h7F, 1'b1);
        total++; if (err_invalid !== '0) $display("FAIL inv_clr: got %b expected 0", err_invalid); else passed++;
        step(1'b1, sel_of(4), BAD, 1'b1);
        total++; if (err_invalid !== 6'b010000) $display("FAIL inv_clr_race: got %b expected 010000", err_invalid); else passed++;
        step(1'b1, sel_of(4), 7'b1111000, 1'b0);
        total++; if (bcd_out[19:16] !== 4'h7) $display("FAIL inv_after: got %h expected 7", bcd_out[19:16]); else passed++;
    endtask

    task automatic test_mux();
        step(1'b1, 6'b111100, 7'b0010000, 1'b0);
        total++; if (err_mux !== 1'b1) $display("FAIL mux_two: got %b expected 1", err_mux); else passed++;
        total++; if (bcd_out !== m_bcd) $display("FAIL mux_two_bcd: got %h expected %h", bcd_out, m_bcd); else passed++;
        total++; if (err_invalid !== m_inv) $display("FAIL mux_two_inv: got %b expected %b", err_invalid, m_inv); else passed++;
        step(1'b0, '1, 7'h7F, 1'b1);
        total++; if (err_mux !== 1'b0) $display("FAIL mux_clr: got %b expected 0", err_mux); else passed++;
        step(1'b1, 6'b111111, BAD, 1'b0);
        total++; if (err_mux !== 1'b1 || bcd_out !== m_bcd) $display("FAIL mux_none: got %b/%h expected 1/%h", err_mux, bcd_out, m_bcd); else passed++;
    endtask

    task automatic test_reset_midfilter();
        apply_reset();
        step(1'b1, sel_of(1), 7'b0110000, 1'b0);
        step(1'b1, sel_of(1), 7'b0110000, 1'b0);
        apply_reset();
        for (int n = 1; n <= 3; n++) begin
            step(1'b1, sel_of(1), 7'b0110000, 1'b0);
            total++;
            if (bcd_out[7:4] !== (n == 3 ? 4'h3 : 4'hF))
                $display("FAIL midrst_s%0d: got %h expected %h", n, bcd_out[7:4], (n == 3 ? 4'h3 : 4'hF));
            else passed++;
        end
    endtask

    task automatic test_frame();
        int disp [ND] = '{6, 5, 4, 3, 2, 1};
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            for (int d = 0; d < ND; d++) begin
                step(1'b1, sel_of(d), seg_tab[disp[d]], 1'b0);
                total++;
                if (frame_done !== (d == ND - 1 && p >= 2))
                    $display("FAIL frame_p%0d_d%0d: got %b expected %0d", p, d, frame_done, (d == ND - 1 && p >= 2));
                else passed++;
            end
            if (p == 2) begin
                total++; if (bcd_out !== 24'h123456) $display("FAIL frame_bcd: got %h expected 123456", bcd_out); else passed++;
                total++; if (digit_valid !== '1) $display("FAIL frame_valid: got %b expected 111111", digit_valid); else passed++;
            end
        end
        step(1'b0, '1, 7'h7F, 1'b0);
        total++; if (frame_done !== 1'b0) $display("FAIL frame_pulse_len: got %b expected 0", frame_done); else passed++;
    endtask

    task automatic test_random();
        int d, r, reps;
        logic [6:0] s;
        logic [ND-1:0] sel;
        logic en, clr;
        apply_reset();
        for (int it = 0; it < 150; it++) begin
            d = $urandom_range(0, ND - 1);
            r = $urandom_range(0, 19);
            s = (r == 0) ? BAD : (r == 1) ? 7'h7F : seg_tab[$urandom_range(0, 2)];
            reps = $urandom_range(1, 4);
            for (int k = 0; k < reps; k++) begin
                sel = ($urandom_range(0, 14) == 0) ? ND'($urandom) : sel_of(d);
                en  = ($urandom_range(0, 9) != 0);
                clr = ($urandom_range(0, 19) == 0);
                step(en, sel, s, clr);
                total++;
                if ({bcd_out, digit_valid, err_invalid, err_mux, frame_done} !== {m_bcd, m_valid, m_inv, m_mux, m_frame})
                    $display("FAIL rand_%0d: got %h %b %b %b %b expected %h %b %b %b %b", it, bcd_out, digit_valid,
                             err_invalid, err_mux, frame_done, m_bcd, m_valid, m_inv, m_mux, m_frame);
                else passed++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; sample_en = 1'b0; err_clr = 1'b0; seg = 7'h7F; dig_sel = '1;
        model_reset();
        test_reset();
        test_stability();
        test_no_false_commit();
        test_invalid();
        test_mux();
        test_reset_midfilter();
        test_frame();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
